dmem_access_ctrl: RTL and testbench

//  Sequences MEM-stage loads/stores onto a valid/ready data bus with a separate response channel.

---
 rtl/dmem_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-bus controller: one valid/ready transaction per load/store, stalling the
// pipeline until the response arrives, with store lane steering and load extension.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req_valid,
  input  logic        mem_is_store,
  input  logic [2:0]  Load_type_mem,
  input  logic [1:0]  Store_type_mem,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dbus_valid,
  input  logic        dbus_ready,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_strb,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [1:0] acc_size(input logic st, input logic [2:0] lt,
                                          input logic [1:0] stt);
    logic [1:0] sz;
    sz = SZ_W;
    if (st) begin
      case (stt)
        2'b01:   sz = SZ_H;
        2'b10:   sz = SZ_B;
        default: sz = SZ_W;
      endcase
    end else begin
      case (lt)
        3'b001, 3'b011: sz = SZ_H;
        3'b010, 3'b111: sz = SZ_B;
        default:        sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
    logic ok;
    case (sz)
      SZ_W:    ok = (off == 2'b00);
      SZ_H:    ok = ~off[0];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] s;
    case (sz)
      SZ_H:    s = 4'b0011 << off;
      SZ_B:    s = 4'b0001 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    case (sz)
      SZ_H:    w = {2{wd[15:0]}};
      SZ_B:    w = {4{wd[7:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] lt, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = rd >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (lt)
      3'b010:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b111:  r = {24'd0, sh[7:0]};
      3'b011:  r = {16'd0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  state_t            state, state_nxt;
  logic [31:0]       addr_p1, wdata_p1, ld_data_p2;
  logic [3:0]        strb_p1;
  logic [2:0]        ltype_p1;
  logic [1:0]        off_p1;
  logic              we_p1, err_p2;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        req_size;
  logic              req_aligned, accept, resp_end;

  assign req_size    = acc_size(mem_is_store, Load_type_mem, Store_type_mem);
  assign req_aligned = is_aligned(req_size, mem_addr[1:0]);
  assign accept      = (state == IDLE) && mem_req_valid && req_aligned;
  assign resp_end    = dbus_rvalid || (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ:  if (dbus_ready) state_nxt = RESP;
      RESP: if (resp_end) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p1: request fields captured in IDLE and held for the whole bus transaction
  // p2: response capture / error flag, presented in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      strb_p1    <= '0;
      ltype_p1   <= '0;
      off_p1     <= '0;
      we_p1      <= 1'b0;
      cnt        <= '0;
      err_p2     <= 1'b0;
      ld_data_p2 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_p1  <= {mem_addr[31:2], 2'b00};
        off_p1   <= mem_addr[1:0];
        we_p1    <= mem_is_store;
        ltype_p1 <= Load_type_mem;
        wdata_p1 <= store_lanes(req_size, mem_wdata);
        strb_p1  <= mem_is_store ? store_strb(req_size, mem_addr[1:0]) : 4'b0000;
        cnt      <= '0;
        err_p2   <= 1'b0;
      end
      if (state == RESP) begin
        if (dbus_rvalid) begin
          err_p2 <= 1'b0;
          if (!we_p1) ld_data_p2 <= load_extract(ltype_p1, off_p1, dbus_rdata);
        end else if (cnt == CNT_LAST) begin
          err_p2     <= 1'b1;
          ld_data_p2 <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Combinational terms are qualified by rst_n so every output is 0 while reset is held.
  assign mem_stall    = rst_n && (accept || (state == REQ) || (state == RESP));
  assign misalign_err = rst_n && (state == IDLE) && mem_req_valid && !req_aligned;
  assign dbus_valid   = (state == REQ);
  assign dbus_we      = we_p1;
  assign dbus_addr    = addr_p1;
  assign dbus_wdata   = wdata_p1;
  assign dbus_strb    = strb_p1;
  assign ld_valid     = (state == DONE) && !we_p1 && !err_p2;
  assign bus_err      = (state == DONE) && err_p2;
  assign ld_data      = ld_data_p2;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: load/store lanes, misalignment, timeout and reset abort.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid, mem_is_store;
  logic [2:0]  Load_type_mem;
  logic [1:0]  Store_type_mem;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_stall, ld_valid, misalign_err, bus_err;
  logic [31:0] ld_data;
  logic        dbus_valid, dbus_ready, dbus_we, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_strb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(256), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_is_store(mem_is_store),
    .Load_type_mem(Load_type_mem), .Store_type_mem(Store_type_mem),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .dbus_valid(dbus_valid), .dbus_ready(dbus_ready), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_strb(dbus_strb),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one aligned access from IDLE; called at posedge+1, returns at posedge+1 back in IDLE.
  task automatic run_access(input logic st, input logic [2:0] lt, input logic [1:0] stt,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            input int rdy_wait, input logic [31:0] ea, input logic [31:0] ew,
                            input logic [3:0] es, input logic [31:0] el);
    mem_req_valid = 1'b1; mem_is_store = st; Load_type_mem = lt; Store_type_mem = stt;
    mem_addr = a; mem_wdata = wd; dbus_ready = (rdy_wait == 0);
    #4;
    chk1("idle_stall", mem_stall, 1'b1);
    chk1("idle_noval", dbus_valid, 1'b0);
    chk1("idle_nomis", misalign_err, 1'b0);
    next_cyc();
    mem_wdata = ~wd;
    for (int i = 0; i <= rdy_wait; i++) begin
      dbus_ready = (i == rdy_wait);
      #4;
      chk1("req_valid", dbus_valid, 1'b1);
      chk1("req_stall", mem_stall, 1'b1);
      chk1("req_we", dbus_we, st);
      chk("req_addr", dbus_addr, ea);
      chk("req_strb", {28'd0, dbus_strb}, {28'd0, es});
      if (st) chk("req_wdata", dbus_wdata, ew);
      next_cyc();
    end
    dbus_ready = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = rd;
    #4;
    chk1("resp_stall", mem_stall, 1'b1);
    chk1("resp_noval", dbus_valid, 1'b0);
    next_cyc();
    dbus_rvalid = 1'b0; dbus_rdata = 32'h0; mem_wdata = wd;
    #4;
    chk1("done_stall", mem_stall, 1'b0);
    chk1("done_ldv", ld_valid, !st);
    chk1("done_berr", bus_err, 1'b0);
    if (!st) chk("done_ldata", ld_data, el);
    next_cyc();
    mem_req_valid = 1'b0;
    #4;
    chk1("post_ldv", ld_valid, 1'b0);
    chk1("post_stall", mem_stall, 1'b0);
    chk1("post_noval", dbus_valid, 1'b0);
    next_cyc();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; mem_req_valid = 1'b0; mem_is_store = 1'b0;
    Load_type_mem = 3'b000; Store_type_mem = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    dbus_ready = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
    #2;
    chk1("rst_stall", mem_stall, 1'b0);
    chk1("rst_valid", dbus_valid, 1'b0);
    chk1("rst_ldv", ld_valid, 1'b0);
    chk("rst_ldata", ld_data, 32'h0);
    chk1("rst_berr", bus_err, 1'b0);
    chk("rst_strb", {28'd0, dbus_strb}, 32'h0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    run_access(1'b0, 3'b000, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
    run_access(1'b0, 3'b010, 2'b00, 32'h103, 32'h0, 32'h80FF0000, 2, 32'h100, 32'h0, 4'h0, 32'hFFFFFF80);
    run_access(1'b0, 3'b111, 2'b00, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h100, 32'h0, 4'h0, 32'h00000080);
    run_access(1'b1, 3'b000, 2'b01, 32'h202, 32'h0000ABCD, 32'h0, 1, 32'h200, 32'hABCDABCD, 4'b1100, 32'h0);
    run_access(1'b0, 3'b001, 2'b00, 32'h102, 32'h0, 32'h80011234, 0, 32'h100, 32'h0, 4'h0, 32'hFFFF8001);
    run_access(1'b0, 3'b011, 2'b00, 32'h102, 32'h0, 32'h80011234, 0, 32'h100, 32'h0, 4'h0, 32'h00008001);
    run_access(1'b1, 3'b000, 2'b10, 32'h101, 32'h0000005A, 32'h0, 0, 32'h100, 32'h5A5A5A5A, 4'b0010, 32'h0);
    run_access(1'b1, 3'b000, 2'b00, 32'h304, 32'h12345678, 32'h0, 0, 32'h304, 32'h12345678, 4'b1111, 32'h0);

    // misaligned word store, then misaligned half load
    mem_req_valid = 1'b1; mem_is_store = 1'b1; Store_type_mem = 2'b00; mem_addr = 32'h101;
    #4;
    chk1("mis_sw_err", misalign_err, 1'b1);
    chk1("mis_sw_stall", mem_stall, 1'b0);
    chk1("mis_sw_valid", dbus_valid, 1'b0);
    next_cyc();
    mem_is_store = 1'b0; Load_type_mem = 3'b001; mem_addr = 32'h103;
    #4;
    chk1("mis_lh_err", misalign_err, 1'b1);
    chk1("mis_lh_valid", dbus_valid, 1'b0);
    next_cyc();
    mem_req_valid = 1'b0;
    #4;
    chk1("mis_pulse_end", misalign_err, 1'b0);
    chk1("mis_idle_valid", dbus_valid, 1'b0);
    next_cyc();

    // asynchronous reset while waiting in RESP
    mem_req_valid = 1'b1; mem_is_store = 1'b0; Load_type_mem = 3'b000; mem_addr = 32'h400;
    dbus_ready = 1'b1;
    next_cyc();
    next_cyc();
    dbus_ready = 1'b0;
    #1;
    chk1("pre_rst_stall", mem_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("arst_stall", mem_stall, 1'b0);
    chk1("arst_valid", dbus_valid, 1'b0);
    chk("arst_ldata", ld_data, 32'h0);
    chk1("arst_ldv", ld_valid, 1'b0);
    next_cyc();
    rst_n = 1'b1; mem_req_valid = 1'b0;
    next_cyc();
    run_access(1'b0, 3'b000, 2'b00, 32'h104, 32'h0, 32'h12345678, 0, 32'h104, 32'h0, 4'h0, 32'h12345678);

    // ready held low 5 cycles, then no response ever
    mem_req_valid = 1'b1; mem_is_store = 1'b1; Store_type_mem = 2'b10; mem_addr = 32'h302;
    mem_wdata = 32'h000000C3; dbus_ready = 1'b0;
    next_cyc();
    mem_wdata = 32'h0; mem_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      dbus_ready = (i == 5);
      #4;
      chk1("hold_valid", dbus_valid, 1'b1);
      chk("hold_addr", dbus_addr, 32'h300);
      chk("hold_wdata", dbus_wdata, 32'hC3C3C3C3);
      chk("hold_strb", {28'd0, dbus_strb}, 32'h4);
      next_cyc();
    end
    dbus_ready = 1'b0;
    n = 0;
    while (mem_stall && n < 400) begin
      n++;
      next_cyc();
    end
    chk("resp_cycles", n, 32'd256);
    #4;
    chk1("to_berr", bus_err, 1'b1);
    chk1("to_ldv", ld_valid, 1'b0);
    chk("to_ldata", ld_data, 32'h0);
    chk1("to_stall", mem_stall, 1'b0);
    next_cyc();
    mem_req_valid = 1'b0;
    #4;
    chk1("to_berr_end", bus_err, 1'b0);
    chk1("to_idle_valid", dbus_valid, 1'b0);
    next_cyc();

    // a load after the timeout sees a clean path
    run_access(1'b0, 3'b010, 2'b00, 32'h001, 32'h0, 32'h00007F00, 0, 32'h000, 32'h0, 4'h0, 32'h0000007F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
